univ_shift_register: RTL and testbench
======================================

# univ_shift_register

Parametrised universal shift register, the successor to the single-mode shift register. It adds runtime-selectable shift/rotate/arithmetic modes, multi-bit lanes per step, and an autonomous burst engine that performs N steps from one start pulse. It serves as the serialiser/deserialiser and bit-manipulation stage in the datapath.

## Interface
- WIDTH, 8, register width; WIDTH % LANE == 0 required.
- LANE, 1, bits moved per shift step; 1 <= LANE < WIDTH.
- SVALUE, all ones, value loaded by sset.
- CNT_W, 4, width of burst count.

- clk  in  1  clock, all state on rising edge.
- aclr  in  1  asynchronous, active-high reset. Sets q=0, shiftout=0, busy=0, done=0, state IDLE.
- enable  in  1  clock enable. When 0, all state holds, except that done still self-clears.
- sclr  in  1  synchronous clear: q=0.
- sset  in  1  synchronous set: q=SVALUE.
- load  in  1  synchronous parallel load: q=data.
- data  in  WIDTH  parallel load value.
- shift  in  1  single-step request, honoured only in IDLE.
- start  in  1  burst request, honoured only in IDLE.
- count  in  CNT_W  number of burst steps.
- mode  in  3  operation select:
  - 000 SLL, logical shift left
  - 001 SRL, logical shift right
  - 010 ROL, rotate left
  - 011 ROR, rotate right
  - 100 SRA, arithmetic shift right
  - 101–111 no-op step: q and shiftout hold; a burst still counts the step.
- shiftin  in  LANE  serial input lane, used by SLL/SRL only.
- shiftout  out  LANE  registered lane shifted out on the last step.
- q  out  WIDTH  register contents.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- Step definitions, with W=WIDTH and L=LANE:
  - SLL: q <= {q[W-L-1:0], shiftin}; shiftout <= q[W-1:W-L].
  - SRL: q <= {shiftin, q[W-1:L]}; shiftout <= q[L-1:0].
  - ROL: q <= {q[W-L-1:0], q[W-1:W-L]}; shiftout <= q[W-1:W-L].
  - ROR: q <= {q[L-1:0], q[W-1:L]}; shiftout <= q[L-1:0].
  - SRA: q <= {{L{q[W-1]}}, q[W-1:L]}; shiftout <= q[L-1:0].
- shiftout changes only on a step. It holds through load, sclr and sset.
- Priority per enabled edge: sclr > sset > load > start > shift.
- FSM states: IDLE and BURST.
- IDLE:
  - start=1 and count!=0: latch mode and count into internal registers; go to BURST; busy=1. No step occurs on this edge.
  - start=1 and count==0: stay in IDLE; done=1 next cycle; no step.
  - shift=1 (without start): one step using the live mode.
- BURST:
  - Each enabled edge performs one step using the latched mode and decrements the remaining count.
  - On the edge performing the last step: go to IDLE, busy=0, done=1.
  - start and shift are ignored while busy.
  - mode changes during a burst have no effect.
- Abort: sclr, sset or load during BURST applies its normal action, forces IDLE, sets busy=0, and does not pulse done.
- Stall: enable=0 freezes the burst, and the remaining count is preserved.
- aclr at any time, including mid-burst: immediate return to reset values, with no done pulse.

## Timing
- start sampled at edge k with count=N: steps occur at edges k+1 … k+N, provided enable stays 1.
- busy is high from after edge k to after edge k+N. done is high for the one cycle after edge k+N.
- A new start is accepted at edge k+N+1, so back-to-back bursts have a one-cycle gap.
- Single step: shift sampled at edge k updates q and shiftout after edge k. Latency is 1 cycle and throughput is 1 step per cycle.
- done clears on the next clk edge regardless of enable.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset and load:
  - aclr pulse: q=0x00, shiftout=0, busy=0, done=0.
  - load 0xA5 → q=0xA5.
  - sset (enable=1) → q=0xFF.
  - sclr → q=0x00.
  - With enable=0, sset has no effect.
- Single steps, WIDTH=8, LANE=1, q=0x81:
  - SLL, shiftin=0 → q=0x02, shiftout=1.
  - ROR → q=0xC0, shiftout=1.
  - SRA from q=0x80 → q=0xC0, shiftout=0.
- Lane variant, WIDTH=8, LANE=2, q=0xB4:
  - SRL, shiftin=2'b11 → q=0xED, shiftout=2'b00.
  - ROL from 0xB4 → q=0xD2, shiftout=2'b10.
- Burst:
  - q=0x01, ROL, start with count=3, mode switched to SRL after start: q is 0x08 after 3 steps; busy high for exactly 3 cycles; done is a single pulse.
  - count=0: done pulses, q unchanged, busy never asserts.
- Stall and abort:
  - enable=0 for 2 cycles mid-burst of 4 steps: total busy duration is 6 cycles and the step count stays correct.
  - load 0x3C mid-burst: q=0x3C, busy=0, no done.
  - aclr mid-burst: all outputs return to reset values.
- Ignored requests: start or shift while busy, and mode 101: no extra steps, burst length unchanged.

Source files
------------

// File: rtl/univ_shift_register_if.sv
// Handshake bundle for univ_shift_register.
// The master drives the controls and data; the slave returns q, shiftout, busy and done.
interface univ_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int LANE  = 1,
    parameter int CNT_W = 4
);
    logic             enable;
    logic             sclr;
    logic             sset;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             shift;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [2:0]       mode;
    logic [LANE-1:0]  shiftin;
    logic [LANE-1:0]  shiftout;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output enable, sclr, sset, load, data,
        output shift, start, count, mode, shiftin,
        input  shiftout, q, busy, done
    );

    modport slave (
        input  enable, sclr, sset, load, data,
        input  shift, start, count, mode, shiftin,
        output shiftout, q, busy, done
    );
endinterface

// File: rtl/univ_shift_register.sv
// Universal shift register: shift, rotate and arithmetic modes in LANE-bit steps.
// It can run a single step, or a burst of count steps from one start pulse.
module univ_shift_register #(
    parameter int               WIDTH  = 8,
    parameter int               LANE   = 1,
    parameter logic [WIDTH-1:0] SVALUE = '1,
    parameter int               CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 aclr,
    univ_shift_register_if.slave bus_if
);
    localparam int W = WIDTH;
    localparam int L = LANE;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     q_q, q_d;
    logic [L-1:0]     so_q, so_d;
    logic             done_q, done_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Returns {shiftout, q} after one step; reserved modes hold both.
    function automatic logic [L+W-1:0] step_f(
        input logic [2:0]   m,
        input logic [W-1:0] v,
        input logic [L-1:0] si,
        input logic [L-1:0] so
    );
        logic [L+W-1:0] r;
        case (m)
            3'b000:  r = {v[W-1:W-L], v[W-L-1:0], si};
            3'b001:  r = {v[L-1:0], si, v[W-1:L]};
            3'b010:  r = {v[W-1:W-L], v[W-L-1:0], v[W-1:W-L]};
            3'b011:  r = {v[L-1:0], v[L-1:0], v[W-1:L]};
            3'b100:  r = {v[L-1:0], {L{v[W-1]}}, v[W-1:L]};
            default: r = {so, v};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        so_d    = so_q;
        done_d  = 1'b0;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (bus_if.enable) begin
            if (bus_if.sclr) begin
                q_d     = '0;
                state_d = IDLE;
            end else if (bus_if.sset) begin
                q_d     = SVALUE;
                state_d = IDLE;
            end else if (bus_if.load) begin
                q_d     = bus_if.data;
                state_d = IDLE;
            end else if (state_q == BURST) begin
                {so_d, q_d} = step_f(mode_q, q_q, bus_if.shiftin, so_q);
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else if (bus_if.start) begin
                if (bus_if.count != '0) begin
                    mode_d  = bus_if.mode;
                    cnt_d   = bus_if.count;
                    state_d = BURST;
                end else begin
                    done_d = 1'b1;
                end
            end else if (bus_if.shift) begin
                {so_d, q_d} = step_f(bus_if.mode, q_q, bus_if.shiftin, so_q);
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            q_q     <= '0;
            so_q    <= '0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_if.q        = q_q;
    assign bus_if.shiftout = so_q;
    assign bus_if.busy     = (state_q == BURST);
    assign bus_if.done     = done_q;
endmodule

// File: tb/tb_univ_shift_register.sv
// Bench for univ_shift_register: a LANE=1 and a LANE=2 instance, directed vectors,
// burst corner sequences and random traffic against an arithmetic reference model.
module tb_univ_shift_register;
    logic clk = 1'b0;
    logic aclr = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    univ_shift_register_if #(.WIDTH(8), .LANE(1), .CNT_W(4)) b0 ();
    univ_shift_register_if #(.WIDTH(8), .LANE(2), .CNT_W(4)) b1 ();

    univ_shift_register #(.WIDTH(8), .LANE(1), .SVALUE(8'hFF), .CNT_W(4))
        u0 (.clk(clk), .aclr(aclr), .bus_if(b0.slave));
    univ_shift_register #(.WIDTH(8), .LANE(2), .SVALUE(8'hFF), .CNT_W(4))
        u1 (.clk(clk), .aclr(aclr), .bus_if(b1.slave));

    typedef struct {
        int         id;
        bit         en, sc, ss, ld;
        bit [7:0]   d;
        bit         sh;
        bit [2:0]   md;
        bit [1:0]   si;
        bit [7:0]   eq;
        bit [1:0]   eso;
    } vec_t;

    vec_t tv[15];

    // Reference model state, per instance
    int mq[2], mso[2], mrem[2], mbmode[2], mdone[2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(int id, bit en, bit sc, bit ss, bit ld, bit [7:0] d,
                       bit sh, bit st, bit [3:0] cnt, bit [2:0] md, bit [1:0] si);
        if (id == 0) begin
            b0.enable = en; b0.sclr = sc; b0.sset = ss; b0.load = ld;
            b0.data = d; b0.shift = sh; b0.start = st; b0.count = cnt;
            b0.mode = md; b0.shiftin = si[0];
        end else begin
            b1.enable = en; b1.sclr = sc; b1.sset = ss; b1.load = ld;
            b1.data = d; b1.shift = sh; b1.start = st; b1.count = cnt;
            b1.mode = md; b1.shiftin = si;
        end
    endtask

    task automatic idle(int id);
        drv(id, 1, 0, 0, 0, 8'h00, 0, 0, 4'd0, 3'd0, 2'd0);
    endtask

    function automatic vec_t mk(int id, bit en, bit sc, bit ss, bit ld, bit [7:0] d,
                                bit sh, bit [2:0] md, bit [1:0] si,
                                bit [7:0] eq, bit [1:0] eso);
        vec_t v;
        v.id = id; v.en = en; v.sc = sc; v.ss = ss; v.ld = ld; v.d = d;
        v.sh = sh; v.md = md; v.si = si; v.eq = eq; v.eso = eso;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mso[i] = 0; mrem[i] = 0; mbmode[i] = 0; mdone[i] = 0;
        end
    endfunction

    // One step of mode md on an 8-bit value, moving L bits, in plain integer arithmetic
    function automatic void do_step(int id, int L, int md, int si);
        int v, mask;
        v = mq[id];
        mask = (1 << L) - 1;
        case (md)
            0: begin mso[id] = v >> (8 - L); mq[id] = ((v << L) | si) & 255; end
            1: begin mso[id] = v & mask; mq[id] = (si << (8 - L)) | (v >> L); end
            2: begin mso[id] = v >> (8 - L); mq[id] = ((v << L) | (v >> (8 - L))) & 255; end
            3: begin mso[id] = v & mask; mq[id] = ((v & mask) << (8 - L)) | (v >> L); end
            4: begin
                mso[id] = v & mask;
                mq[id] = (v >= 128) ? ((v >> L) | (255 & ~(255 >> L))) : (v >> L);
            end
            default: ;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_edge(int id);
        int en, sc, ss, ld, d, sh, st, cnt, md, si, L;
        if (id == 0) begin
            en = b0.enable; sc = b0.sclr; ss = b0.sset; ld = b0.load; d = b0.data;
            sh = b0.shift; st = b0.start; cnt = b0.count; md = b0.mode;
            si = b0.shiftin; L = 1;
        end else begin
            en = b1.enable; sc = b1.sclr; ss = b1.sset; ld = b1.load; d = b1.data;
            sh = b1.shift; st = b1.start; cnt = b1.count; md = b1.mode;
            si = b1.shiftin; L = 2;
        end
        mdone[id] = 0;
        if (en != 0) begin
            if (sc != 0 || ss != 0 || ld != 0) begin
                mq[id] = (sc != 0) ? 0 : (ss != 0) ? 255 : d;
                mrem[id] = 0;
            end else if (mrem[id] != 0) begin
                do_step(id, L, mbmode[id], si);
                mrem[id]--;
                if (mrem[id] == 0) mdone[id] = 1;
            end else if (st != 0) begin
                if (cnt == 0) mdone[id] = 1;
                else begin mrem[id] = cnt; mbmode[id] = md; end
            end else if (sh != 0) begin
                do_step(id, L, md, si);
            end
        end
    endtask

    task automatic cmp_model(int id);
        if (id == 0) begin
            chk("rnd0.q", 32'(b0.q), 32'(mq[0]));
            chk("rnd0.so", 32'(b0.shiftout), 32'(mso[0]));
            chk("rnd0.busy", 32'(b0.busy), 32'(mrem[0] != 0));
            chk("rnd0.done", 32'(b0.done), 32'(mdone[0]));
        end else begin
            chk("rnd1.q", 32'(b1.q), 32'(mq[1]));
            chk("rnd1.so", 32'(b1.shiftout), 32'(mso[1]));
            chk("rnd1.busy", 32'(b1.busy), 32'(mrem[1] != 0));
            chk("rnd1.done", 32'(b1.done), 32'(mdone[1]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(int n, inout int bc, inout int dc);
        for (int i = 0; i < n; i++) begin
            tick();
            bc += int'(b0.busy);
            dc += int'(b0.done);
        end
    endtask

    initial begin
        int bc, dc;
        idle(0);
        idle(1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.q", 32'(b0.q), 32'h00);
        chk("rst.so", 32'(b0.shiftout), 32'h0);
        chk("rst.busy", 32'(b0.busy), 32'h0);
        chk("rst.done", 32'(b0.done), 32'h0);
        aclr = 1'b0;

        tv[0]  = mk(0, 1, 0, 0, 1, 8'hA5, 0, 0, 0, 8'hA5, 0);
        tv[1]  = mk(0, 1, 0, 1, 0, 8'h00, 0, 0, 0, 8'hFF, 0);
        tv[2]  = mk(0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        tv[3]  = mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        tv[4]  = mk(0, 1, 0, 0, 1, 8'h81, 0, 0, 0, 8'h81, 0);
        tv[5]  = mk(0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 8'h02, 1);
        tv[6]  = mk(0, 1, 0, 0, 1, 8'h81, 0, 0, 0, 8'h81, 1);
        tv[7]  = mk(0, 1, 0, 0, 0, 8'h00, 1, 3, 0, 8'hC0, 1);
        tv[8]  = mk(0, 1, 0, 0, 1, 8'h80, 0, 0, 0, 8'h80, 1);
        tv[9]  = mk(0, 1, 0, 0, 0, 8'h00, 1, 4, 0, 8'hC0, 0);
        tv[10] = mk(0, 1, 0, 0, 0, 8'h00, 1, 5, 1, 8'hC0, 0);
        tv[11] = mk(1, 1, 0, 0, 1, 8'hB4, 0, 0, 0, 8'hB4, 0);
        tv[12] = mk(1, 1, 0, 0, 0, 8'h00, 1, 1, 3, 8'hED, 0);
        tv[13] = mk(1, 1, 0, 0, 1, 8'hB4, 0, 0, 0, 8'hB4, 0);
        tv[14] = mk(1, 1, 0, 0, 0, 8'h00, 1, 2, 0, 8'hD2, 2);

        for (int i = 0; i < 15; i++) begin
            idle(1 - tv[i].id);
            drv(tv[i].id, tv[i].en, tv[i].sc, tv[i].ss, tv[i].ld, tv[i].d,
                tv[i].sh, 0, 4'd0, tv[i].md, tv[i].si);
            tick();
            if (tv[i].id == 0) begin
                chk($sformatf("vec%0d.q", i), 32'(b0.q), 32'(tv[i].eq));
                chk($sformatf("vec%0d.so", i), 32'(b0.shiftout), 32'(tv[i].eso));
            end else begin
                chk($sformatf("vec%0d.q", i), 32'(b1.q), 32'(tv[i].eq));
                chk($sformatf("vec%0d.so", i), 32'(b1.shiftout), 32'(tv[i].eso));
            end
        end
        idle(1);

        // Burst of 3 ROL; mode switched after start must not matter
        drv(0, 1, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0); tick();
        bc = 0; dc = 0;
        drv(0, 1, 0, 0, 0, 8'h00, 0, 1, 4'd3, 3'd2, 0);
        run_n(1, bc, dc);
        chk("burst.q_at_start", 32'(b0.q), 32'h01);
        drv(0, 1, 0, 0, 0, 8'h00, 0, 0, 4'd0, 3'd1, 0);
        run_n(5, bc, dc);
        chk("burst.q", 32'(b0.q), 32'h08);
        chk("burst.busy_cycles", 32'(bc), 32'd3);
        chk("burst.done_pulses", 32'(dc), 32'd1);

        // count == 0
        drv(0, 1, 0, 0, 0, 8'h00, 0, 1, 4'd0, 3'd2, 0); tick();
        chk("cnt0.done", 32'(b0.done), 32'h1);
        chk("cnt0.busy", 32'(b0.busy), 32'h0);
        chk("cnt0.q", 32'(b0.q), 32'h08);
        idle(0); tick();
        chk("cnt0.done_clr", 32'(b0.done), 32'h0);

        // Stall for 2 cycles in a 4-step burst
        drv(0, 1, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0); tick();
        bc = 0; dc = 0;
        drv(0, 1, 0, 0, 0, 8'h00, 0, 1, 4'd4, 3'd2, 0); run_n(1, bc, dc);
        drv(0, 1, 0, 0, 0, 8'h00, 0, 0, 4'd0, 3'd1, 0); run_n(1, bc, dc);
        drv(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 3'd1, 0); run_n(2, bc, dc);
        drv(0, 1, 0, 0, 0, 8'h00, 0, 0, 4'd0, 3'd1, 0); run_n(6, bc, dc);
        chk("stall.q", 32'(b0.q), 32'h10);
        chk("stall.busy_cycles", 32'(bc), 32'd6);
        chk("stall.done_pulses", 32'(dc), 32'd1);

        // Load aborts a burst without a done pulse
        drv(0, 1, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0); tick();
        bc = 0; dc = 0;
        drv(0, 1, 0, 0, 0, 8'h00, 0, 1, 4'd4, 3'd2, 0); run_n(1, bc, dc);
        idle(0); run_n(2, bc, dc);
        chk("abort.mid_q", 32'(b0.q), 32'h04);
        drv(0, 1, 0, 0, 1, 8'h3C, 0, 0, 0, 0, 0); run_n(1, bc, dc);
        chk("abort.q", 32'(b0.q), 32'h3C);
        chk("abort.busy", 32'(b0.busy), 32'h0);
        idle(0); run_n(6, bc, dc);
        chk("abort.q_hold", 32'(b0.q), 32'h3C);
        chk("abort.done_pulses", 32'(dc), 32'd0);

        // aclr mid-burst
        drv(0, 1, 0, 0, 1, 8'h81, 0, 0, 0, 0, 0); tick();
        drv(0, 1, 0, 0, 0, 8'h00, 0, 1, 4'd4, 3'd2, 0); tick();
        idle(0); tick();
        chk("aclr.pre_so", 32'(b0.shiftout), 32'h1);
        #2 aclr = 1'b1;
        #1;
        chk("aclr.q", 32'(b0.q), 32'h00);
        chk("aclr.so", 32'(b0.shiftout), 32'h0);
        chk("aclr.busy", 32'(b0.busy), 32'h0);
        chk("aclr.done", 32'(b0.done), 32'h0);
        #1 aclr = 1'b0;
        bc = 0; dc = 0;
        run_n(6, bc, dc);
        chk("aclr.after_busy", 32'(bc), 32'd0);
        chk("aclr.after_done", 32'(dc), 32'd0);

        // Requests and mode changes during a burst are ignored
        drv(0, 1, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0); tick();
        bc = 0; dc = 0;
        drv(0, 1, 0, 0, 0, 8'h00, 0, 1, 4'd3, 3'd2, 0); run_n(1, bc, dc);
        drv(0, 1, 0, 0, 0, 8'h00, 1, 1, 4'd5, 3'd5, 0); run_n(2, bc, dc);
        idle(0); run_n(3, bc, dc);
        chk("ign.q", 32'(b0.q), 32'h08);
        chk("ign.busy_cycles", 32'(bc), 32'd3);
        chk("ign.done_pulses", 32'(dc), 32'd1);
        bc = 0; dc = 0;
        drv(0, 1, 0, 0, 0, 8'h00, 0, 1, 4'd2, 3'd5, 0); run_n(1, bc, dc);
        idle(0); run_n(3, bc, dc);
        chk("nop.q", 32'(b0.q), 32'h08);
        chk("nop.busy_cycles", 32'(bc), 32'd2);
        chk("nop.done_pulses", 32'(dc), 32'd1);

        // Random traffic on both instances against the model
        aclr = 1'b1;
        #3 aclr = 1'b0;
        model_reset();
        for (int c = 0; c < 2500; c++) begin
            for (int id = 0; id < 2; id++) begin
                drv(id, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                    8'($urandom), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5) == 0, 4'($urandom_range(0, 6)),
                    3'($urandom_range(0, 7)), 2'($urandom));
                model_edge(id);
            end
            tick();
            cmp_model(0);
            cmp_model(1);
            if ($urandom_range(0, 299) == 0) begin
                #2 aclr = 1'b1;
                #1;
                model_reset();
                cmp_model(0);
                cmp_model(1);
                #1 aclr = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
